// File: rtl/mem_copy_engine.sv
// mem_copy_engine: data-segment bus master for block copy (overlap-safe) and block fill.
module mem_copy_engine #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] src,
  input  logic [WIDTH-1:0] dst,
  input  logic [WIDTH-1:0] len,
  input  logic [WIDTH-1:0] fill_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mem_a,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
  state_t           r_state;
  logic             r_mode;
  logic             r_desc;
  logic [AW-1:0]    r_src;
  logic [AW-1:0]    r_dst;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_fill;
  logic [AW-1:0]    w_src;
  logic [AW-1:0]    w_dst;
  logic [AW-1:0]    w_span;
  logic [CW-1:0]    w_cnt;
  logic             w_desc;
  assign w_src  = AW'(src);
  assign w_dst  = AW'(dst);
  assign w_cnt  = (32'(len) >= 32'(DEPTH)) ? CW'(DEPTH) : CW'(len);
  assign w_span = AW'(w_cnt - CW'(1));
  // Copying toward higher addresses walks backwards so overlapping sources are read before being overwritten.
  assign w_desc = !mode && (w_dst > w_src);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_desc  <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_fill  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_mode  <= mode;
          r_fill  <= fill_val;
          r_desc  <= w_desc;
          r_cnt   <= w_cnt;
          r_src   <= w_desc ? w_src + w_span : w_src;
          r_dst   <= w_desc ? w_dst + w_span : w_dst;
          r_state <= (w_cnt == '0) ? S_DONE : mode ? S_WRITE : S_READ;
        end
        S_READ: begin
          r_data  <= mem_rd;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_cnt   <= r_cnt - CW'(1);
          r_src   <= r_desc ? r_src - AW'(1) : r_src + AW'(1);
          r_dst   <= r_desc ? r_dst - AW'(1) : r_dst + AW'(1);
          r_state <= (r_cnt == CW'(1)) ? S_DONE : r_mode ? S_WRITE : S_READ;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign busy   = r_state != S_IDLE;
  assign done   = r_state == S_DONE;
  assign mem_we = r_state == S_WRITE;
  assign mem_a  = (r_state == S_READ) ? WIDTH'(r_src) : (r_state == S_WRITE) ? WIDTH'(r_dst) : '0;
  assign mem_wd = (r_state == S_WRITE) ? (r_mode ? r_fill : r_data) : '0;
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: randomized copy/fill requests against a word-level reference model with a write/done scoreboard.
module tb_mem_copy_engine;
  localparam int D = 32;
  typedef struct {int c; int a; int d;} wr_t;
  logic       clk = 0, rst = 1, start = 0, mode = 0;
  logic [7:0] src = 0, dst = 0, len = 0, fill_val = 0;
  logic [7:0] mem_a, mem_wd, mem_rd;
  logic       busy, done, mem_we;
  logic [7:0] mem[D];
  logic [7:0] refm[D];
  int         cyc = 0, b_lo = 1, b_hi = 0, vectors = 0, errors = 0;
  wr_t        wq[$];
  int         dq[$];
  bit         eb;
  wr_t        e;

  mem_copy_engine #(.WIDTH(8), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done), .mem_a(mem_a),
    .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_we) mem[int'(mem_a) % D] <= mem_wd;
  assign mem_rd = mem[int'(mem_a) % D];

  task automatic chk(string nm, int got, int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic flag(string nm);
    vectors++;
    errors++;
    $display("FAIL %s: event not expected by scoreboard (cycle %0d)", nm, cyc);
  endtask

  always @(negedge clk) begin
    eb = (cyc >= b_lo) && (cyc <= b_hi);
    chk("busy", int'(busy), int'(eb));
    if (!eb) chk("idle_outputs", int'({done, mem_we, mem_a, mem_wd}), 0);
    if (mem_we) begin
      if (wq.size() == 0) flag("unexpected_write");
      else begin
        e = wq.pop_front();
        chk("wr_cycle", cyc, e.c);
        chk("wr_addr", int'(mem_a), e.a);
        chk("wr_data", int'(mem_wd), e.d);
      end
    end
    if (done) begin
      if (dq.size() == 0) flag("unexpected_done");
      else chk("done_cycle", cyc, dq.pop_front());
    end
  end

  task automatic check_image(string nm);
    int bad = 0;
    for (int a = 0; a < D; a++) if (mem[a] !== refm[a]) bad++;
    chk(nm, bad, 0);
    chk("leftover_writes", wq.size(), 0);
  endtask

  task automatic junk_inputs(bit junk);
    start = junk ? 1'($urandom_range(0, 1)) : 1'b0;
    if (junk) begin
      mode = 1'($urandom_range(0, 1));
      src = 8'($urandom); dst = 8'($urandom); len = 8'($urandom); fill_val = 8'($urandom);
    end
  endtask

  task automatic set_word(int a, logic [7:0] v);
    mem[a] = v;
    refm[a] = v;
  endtask

  task automatic run_op(bit m, logic [7:0] s, logic [7:0] d, logic [7:0] l, logic [7:0] fv, bit junk);
    int n, t0, si, di, i, tdone, k;
    bit desc;
    logic [7:0] v;
    n = (int'(l) >= D) ? D : int'(l);
    si = int'(s) % D;
    di = int'(d) % D;
    desc = !m && (di > si);
    t0 = cyc;
    for (k = 0; k < n; k++) begin
      if (m) begin
        refm[(di + k) % D] = fv;
        wq.push_back(wr_t'{t0 + k + 1, (di + k) % D, int'(fv)});
      end else begin
        i = desc ? n - 1 - k : k;
        v = refm[(si + i) % D];
        refm[(di + i) % D] = v;
        wq.push_back(wr_t'{t0 + 2 * (k + 1), (di + i) % D, int'(v)});
      end
    end
    tdone = t0 + ((n == 0) ? 1 : m ? n + 1 : 2 * n + 1);
    dq.push_back(tdone);
    b_lo = t0 + 1;
    b_hi = tdone;
    mode = m; src = s; dst = d; len = l; fill_val = fv; start = 1;
    @(negedge clk);
    for (k = 0; k < 200 && !done; k++) begin
      junk_inputs(junk);
      @(negedge clk);
    end
    if (!done) begin
      flag("done_timeout");
      rst = 1;
      @(negedge clk);
      rst = 0;
      b_hi = 0;
      wq.delete();
      dq.delete();
    end else begin
      junk_inputs(junk);
      @(negedge clk);
      start = 0;
    end
    check_image("memory_image");
  endtask

  task automatic reset_abort();
    int t0;
    for (int a = 0; a < 4; a++) set_word(16 + a, 8'(8'h30 + a));
    t0 = cyc;
    refm[4] = refm[16];
    wq.push_back(wr_t'{t0 + 2, 4, int'(refm[16])});
    b_lo = t0 + 1;
    b_hi = t0 + 3;
    mode = 0; src = 16; dst = 4; len = 4; fill_val = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    chk("pre_abort_we", int'(mem_we), 1);
    rst = 1;
    #1;
    chk("abort_we", int'(mem_we), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    check_image("abort_image");
  endtask

  initial begin
    for (int a = 0; a < D; a++) set_word(a, 8'($urandom));
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_outputs", int'({done, mem_we, mem_a, mem_wd}), 0);
    repeat (3) @(negedge clk);
    rst = 0;
    set_word(0, 8'd11); set_word(1, 8'd22); set_word(2, 8'd33); set_word(3, 8'd44);
    run_op(0, 8'd0, 8'd8, 8'd4, 8'd0, 0);
    for (int a = 0; a < 4; a++) set_word(4 + a, 8'(a + 1));
    run_op(0, 8'd4, 8'd6, 8'd4, 8'd0, 0);
    run_op(1, 8'd0, 8'd30, 8'd4, 8'hA5, 0);
    run_op(0, 8'd3, 8'd9, 8'd0, 8'd0, 0);
    run_op(1, 8'd3, 8'd9, 8'd0, 8'h5A, 0);
    run_op(0, 8'd5, 8'd20, 8'd40, 8'd0, 0);
    run_op(1, 8'd7, 8'd77, 8'd40, 8'h3C, 0);
    run_op(0, 8'd2, 8'd12, 8'd6, 8'd0, 1);
    run_op(0, 8'd200, 8'd35, 8'd5, 8'd0, 1);
    reset_abort();
    run_op(0, 8'd16, 8'd4, 8'd4, 8'd0, 0);
    for (int r = 0; r < 40; r++)
      run_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
             8'($urandom_range(0, 40)), 8'($urandom), 1'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
